// File: rtl/bt_mod_pkg.sv
// Shared constants for the FSK bit modulator: FSM state codes and default half-periods.
// States are plain 2-bit constants so older tools and netlists see a fixed encoding.
package bt_mod_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  localparam int DEF_HALF0 = 4;
  localparam int DEF_HALF1 = 2;

endpackage

// File: rtl/bt_fsk_osc.sv
// Half-period counter and square-wave toggle driving the RF switch; held low while disabled.
// A restart zeroes the counter but keeps the output level, so bit changes stay phase-continuous.
module bt_fsk_osc #(
  parameter int HALF0 = 4,
  parameter int HALF1 = 2,
  parameter int CNT_W = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic bit_sel,
  input  logic restart,
  output logic mod_out
);

  logic [CNT_W-1:0] half_cnt;
  logic [CNT_W-1:0] half_lim;

  assign half_lim = bit_sel ? CNT_W'(HALF1 - 1) : CNT_W'(HALF0 - 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      half_cnt <= '0;
      mod_out  <= 1'b0;
    end else if (!enable) begin
      half_cnt <= '0;
      mod_out  <= 1'b0;
    end else if (restart) begin
      // oscillator step skipped on a bit boundary
      half_cnt <= '0;
    end else if (half_cnt == half_lim) begin
      half_cnt <= '0;
      mod_out  <= ~mod_out;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bt_fsk_bit_modulator.sv
// Serialises a payload LSB-first, one bit per data-rate edge, as binary FSK on mod_out.
// Edge detect, FSM, shift register and bit counter live here; the square wave is in bt_fsk_osc.
module bt_fsk_bit_modulator
  import bt_mod_pkg::*;
#(
  parameter int PAYLOAD_W = 32,
  parameter int LEN_W     = 6,
  parameter int HALF0     = DEF_HALF0,
  parameter int HALF1     = DEF_HALF1,
  parameter int CNT_W     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rate_in,
  input  logic                 start,
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic [LEN_W-1:0]     length,
  output logic                 busy,
  output logic                 done,
  output logic                 bit_out,
  output logic                 mod_out
);

  logic [1:0]           state;
  logic                 rate_q;
  logic                 tick;
  logic [PAYLOAD_W-1:0] sreg;
  logic [LEN_W-1:0]     bits_left;
  logic                 len_ok;
  logic                 load_bit;
  logic                 last_tick;
  logic                 osc_en;
  logic                 osc_restart;

  assign tick        = rate_in ^ rate_q;
  assign len_ok      = (length != '0) && (length <= LEN_W'(PAYLOAD_W));
  assign load_bit    = tick && ((state == ARM) || ((state == SEND) && (bits_left != '0)));
  assign last_tick   = tick && (state == SEND) && (bits_left == '0);
  assign osc_en      = (state == SEND) && !last_tick;
  assign osc_restart = (state == SEND) && tick;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rate_q <= 1'b0;
    else        rate_q <= rate_in;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sreg      <= '0;
      bits_left <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_out   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // a coincident tick is deliberately ignored here
          if (start && len_ok) begin
            sreg      <= payload;
            bits_left <= length;
            busy      <= 1'b1;
            state     <= ARM;
          end
        end
        ARM, SEND: begin
          if (load_bit) begin
            bit_out   <= sreg[0];
            sreg      <= {1'b0, sreg[PAYLOAD_W-1:1]};
            bits_left <= bits_left - 1'b1;
            state     <= SEND;
          end else if (last_tick) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            bit_out <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  bt_fsk_osc #(
    .HALF0 (HALF0),
    .HALF1 (HALF1),
    .CNT_W (CNT_W)
  ) u_osc (
    .clock   (clock),
    .reset   (reset),
    .enable  (osc_en),
    .bit_sel (bit_out),
    .restart (osc_restart),
    .mod_out (mod_out)
  );

endmodule

// File: tb/tb_bt_fsk_bit_modulator.sv
// Bench for bt_fsk_bit_modulator: closed-form per-bit-period model plus directed literal checks.
module tb_bt_fsk_bit_modulator;

  localparam int PW = 32;
  localparam int LW = 6;
  localparam int H0 = 4;
  localparam int H1 = 2;
  localparam int CW = 8;

  logic          clock   = 1'b0;
  logic          reset   = 1'b0;
  logic          rate_in = 1'b0;
  logic          start   = 1'b0;
  logic [PW-1:0] payload = '0;
  logic [LW-1:0] length  = '0;
  logic          busy, done, bit_out, mod_out;

  int total = 0;
  int bad   = 0;
  int rcnt  = 0;

  always #5 clock = ~clock;

  bt_fsk_bit_modulator #(
    .PAYLOAD_W (PW), .LEN_W (LW), .HALF0 (H0), .HALF1 (H1), .CNT_W (CW)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .rate_in (rate_in),
    .start   (start),
    .payload (payload),
    .length  (length),
    .busy    (busy),
    .done    (done),
    .bit_out (bit_out),
    .mod_out (mod_out)
  );

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
    end
  endtask

  // Model: bit period i starts at cycle t0 with level L; level at offset j is L ^ odd(j / half)
  function automatic int half(input bit b);
    return b ? H1 : H0;
  endfunction

  int            m_cyc = 0;
  bit            m_busy, m_armed, m_send, m_prev, m_L;
  int            m_idx, m_len, m_t0;
  logic [PW-1:0] m_pl;
  bit            e_busy, e_done, e_bit, e_mod;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_armed = 0; m_send = 0; m_prev = 0; m_L = 0;
      e_busy = 0; e_done = 0; e_bit = 0; e_mod = 0;
    end else begin
      bit tk;
      tk     = (rate_in != m_prev);
      m_prev = rate_in;
      m_cyc++;
      e_done = 0;
      if (!m_busy) begin
        if (start && length >= 1 && length <= PW) begin
          m_busy = 1; m_armed = 1; m_pl = payload; m_len = int'(length);
        end
      end else if (m_armed) begin
        if (tk) begin
          m_armed = 0; m_send = 1; m_idx = 0; m_t0 = m_cyc; m_L = 0;
        end
      end else if (tk) begin
        if (m_idx == m_len - 1) begin
          e_done = 1; m_busy = 0; m_send = 0;
        end else begin
          m_L = m_L ^ ((((m_cyc - 1 - m_t0) / half(m_pl[m_idx])) % 2) == 1);
          m_idx++;
          m_t0 = m_cyc;
        end
      end
      e_busy = m_busy;
      if (m_send) begin
        e_bit = m_pl[m_idx];
        e_mod = m_L ^ ((((m_cyc - m_t0) / half(e_bit)) % 2) == 1);
      end else begin
        e_bit = 0;
        e_mod = 0;
      end
    end
  end

  always @(negedge clock) begin
    chk("busy", int'(busy), int'(e_busy));
    chk("done", int'(done), int'(e_done));
    chk("bit_out", int'(bit_out), int'(e_bit));
    chk("mod_out", int'(mod_out), int'(e_mod));
  end

  // Stimulus helpers: rate_in toggles every 16 clocks, driven 1ns after the edge
  task automatic step();
    @(posedge clock);
    #1;
    rcnt++;
    if (rcnt == 16) begin
      rcnt = 0;
      rate_in = ~rate_in;
    end
  endtask

  task automatic send(input logic [PW-1:0] p, input logic [LW-1:0] l);
    payload = p;
    length  = l;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_rcnt(input int v);
    int n;
    n = 0;
    while (rcnt != v && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic wait_t0();
    int n;
    step();
    n = 1;
    while (rcnt != 1 && n < 40) begin
      step();
      n++;
    end
    chk("t0_align", rcnt, 1);
  endtask

  // k counts clocks from the first tick; inj>=0 fires a stray start at that offset
  task automatic watch(input int inj, output logic [PW-1:0] bits, output int done_k,
                       output int ndone, output logic [8:0] modv, output logic [1:0] m1920,
                       output int minrun, output int busy_at_done);
    int   run;
    logic last;
    bits = '0; done_k = -1; ndone = 0; modv = '0; m1920 = '0; minrun = 1000; busy_at_done = -1;
    wait_t0();
    run  = 1;
    last = mod_out;
    modv = {8'b0, mod_out};
    for (int k = 0; k < 600; k++) begin
      if (k > 0) begin
        step();
        start = 1'b0;
      end
      if (k > 0 && k <= 8) modv = {modv[7:0], mod_out};
      if (k == 19) m1920[1] = mod_out;
      if (k == 20) m1920[0] = mod_out;
      if ((k % 16) == 8 && (k / 16) < PW) bits[k/16] = bit_out;
      if (done) begin
        ndone++;
        if (done_k < 0) begin
          done_k = k;
          busy_at_done = int'(busy);
        end
      end
      if (k > 0 && done_k < 0) begin
        if (mod_out == last) run++;
        else begin
          if (run < minrun) minrun = run;
          run  = 1;
          last = mod_out;
        end
      end
      if (k == inj) begin
        payload = '1;
        length  = 6'd3;
        start   = 1'b1;
      end
      if (done_k >= 0 && k >= done_k + 20) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] bits;
    logic [8:0]    modv;
    logic [1:0]    m1920;
    int            done_k, ndone, minrun, bad_idle, bsy;

    // reset held with rate toggling
    for (int i = 0; i < 40; i++) step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bit", int'(bit_out), 0);
    chk("rst_mod", int'(mod_out), 0);
    reset = 1'b1;
    bad_idle = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (busy || mod_out || done) bad_idle++;
    end
    chk("idle_quiet", bad_idle, 0);

    // basic: bits 1,0,1
    wait_rcnt(5);
    send(32'h0000_0005, 6'd3);
    watch(-1, bits, done_k, ndone, modv, m1920, minrun, bsy);
    chk("basic_bits", int'(bits[2:0]), 3'b101);
    chk("basic_done_k", done_k, 48);
    chk("basic_ndone", ndone, 1);
    chk("basic_busy_at_done", bsy, 0);
    chk("basic_mod_bit1", int'(modv), 9'b001100110);
    chk("basic_mod_bit0", int'(m1920), 2'b10);

    // stray starts in ARM and in SEND are ignored
    wait_rcnt(5);
    send(32'h0000_0005, 6'd3);
    step(); step(); step();
    send(32'hFFFF_FFFF, 6'd3);
    watch(20, bits, done_k, ndone, modv, m1920, minrun, bsy);
    chk("busy_start_bits", int'(bits[2:0]), 3'b101);
    chk("busy_start_done_k", done_k, 48);
    chk("busy_start_ndone", ndone, 1);

    // invalid lengths
    wait_rcnt(5);
    send(32'h0000_00FF, 6'd0);
    for (int i = 0; i < 3; i++) step();
    chk("len0_busy", int'(busy), 0);
    send(32'h0000_00FF, 6'd33);
    for (int i = 0; i < 3; i++) step();
    chk("len33_busy", int'(busy), 0);

    // start coincident with a rate edge
    wait_rcnt(0);
    send(32'h0000_0001, 6'd1);
    chk("coinc_busy", int'(busy), 1);
    chk("coinc_bit_early", int'(bit_out), 0);
    watch(-1, bits, done_k, ndone, modv, m1920, minrun, bsy);
    chk("coinc_bit", int'(bits[0]), 1);
    chk("coinc_done_k", done_k, 16);

    // reset during bit 2 of an 8-bit transfer
    wait_rcnt(5);
    send(32'h0000_00FF, 6'd8);
    wait_t0();
    for (int i = 0; i < 34; i++) step();
    chk("mid_mod_pre", int'(mod_out), 1);
    chk("mid_busy_pre", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_mod", int'(mod_out), 0);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    bad_idle = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done || busy) bad_idle++;
    end
    chk("abort_no_done", bad_idle, 0);
    wait_rcnt(5);
    send(32'h0000_0005, 6'd3);
    watch(-1, bits, done_k, ndone, modv, m1920, minrun, bsy);
    chk("post_abort_bits", int'(bits[2:0]), 3'b101);
    chk("post_abort_done_k", done_k, 48);

    // full width alternating
    wait_rcnt(5);
    send(32'hAAAA_AAAA, 6'd32);
    watch(-1, bits, done_k, ndone, modv, m1920, minrun, bsy);
    chk("full_bits", int'(bits == 32'hAAAA_AAAA), 1);
    chk("full_done_k", done_k, 512);
    chk("full_ndone", ndone, 1);
    chk("full_minrun_ge2", int'(minrun >= 2), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bt_fsk_bit_modulator.md
Name: bt_fsk_bit_modulator

Overview:
- Downstream consumer of the data-rate generator's square wave. Every transition of that wave marks one bit period.
- Serialises a loaded payload LSB-first, one bit per bit period.
- Drives the backscatter switch with a square wave whose half-period is HALF0 clocks for bit 0 and HALF1 clocks for bit 1 (binary FSK on the reflected Bluetooth carrier).
- Sits between the data-rate block and the RF switch pin; payload and start come from the packet-control logic.

Parameters:
- PAYLOAD_W, 32: payload width in bits.
- LEN_W, 6: width of length input; must satisfy 2^LEN_W > PAYLOAD_W.
- HALF0, 4: mod_out half-period in clocks while sending bit 0. Minimum 1.
- HALF1, 2: mod_out half-period in clocks while sending bit 1. Minimum 1.
- CNT_W, 8: half-period counter width; must hold max(HALF0, HALF1).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- rate_in  in  1  data-rate square wave, same clock domain; each edge (rise or fall) = one bit tick.
- start  in  1  1-cycle request to send; sampled only in IDLE.
- payload  in  PAYLOAD_W  bits to send; bit 0 goes out first; captured on an accepted start.
- length  in  LEN_W  number of bits to send, 1..PAYLOAD_W; captured with payload.
- busy  out  1  high from accepted start until the final bit period ends.
- done  out  1  1-cycle pulse when the last bit period ends.
- bit_out  out  1  bit currently being modulated.
- mod_out  out  1  FSK square wave to the RF switch.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - Ports are named clock and reset.
- Reset values:
  - Outputs: busy=0, done=0, bit_out=0, mod_out=0.
  - Internal: state=IDLE, rate_q=0, shift register=0, bits_left=0, half_cnt=0.
  - Reset asserted mid-operation aborts immediately; no done pulse is produced.
- Tick detection:
  - rate_q registers rate_in every clock.
  - tick = rate_in XOR rate_q (combinational). Tick latency is 1 clock from the rate_in edge.
- State IDLE:
  - busy=0, mod_out held 0, half_cnt held 0.
  - Accept when start=1 and length is nonzero and ≤ PAYLOAD_W: load sreg<=payload, bits_left<=length, busy<=1, go to ARM.
  - start with length=0 or length>PAYLOAD_W is ignored.
  - A tick is ignored in IDLE, even if it coincides with start.
- State ARM:
  - Waits for the next tick.
  - On tick: bit_out<=sreg[0], sreg>>=1 (zero fill), bits_left<=bits_left-1, half_cnt<=0, go to SEND.
  - mod_out stays 0 until the oscillator first toggles.
- State SEND, oscillator:
  - Each clock: if half_cnt == (bit_out ? HALF1 : HALF0) - 1, then mod_out toggles and half_cnt<=0; otherwise half_cnt+1.
- State SEND, on tick with bits_left != 0:
  - Load the next bit (same update as in ARM).
  - half_cnt<=0; mod_out keeps its current level (phase-continuous, no glitch).
  - The oscillator step is skipped that cycle.
- State SEND, on tick with bits_left == 0:
  - done<=1 for one cycle, busy<=0, mod_out<=0, bit_out<=0, go to IDLE.
- Busy and start:
  - start while busy=1 is ignored; it is not queued.
  - A new start is accepted the cycle after done is high.
- Transmission length:
  - Exactly length bit periods of modulation per transmission.
  - The last bit is held for one full tick interval.
- Widths:
  - bits_left is LEN_W bits and never underflows, because it is checked for zero before decrement.
  - half_cnt is CNT_W bits and wraps only by explicit clear.

Decomposition:
- Shared package bt_mod_pkg holds:
  - State encoding constants: IDLE=2'd0, ARM=2'd1, SEND=2'd2.
  - Default HALF0/HALF1 values.
- One natural sub-module, bt_fsk_osc: the half-period counter plus mod_out toggle.
  - Inputs: enable, bit select, restart.
  - Outputs: mod_out.
- The top level keeps the edge detect, FSM, shift register and bit counter.

Test Plan:
- Reset behaviour:
  - Stimulus: reset low, rate_in toggling every 16 clocks.
  - Required: all outputs 0; after release, with no start, busy and mod_out stay 0 indefinitely.
- Basic transmission:
  - Stimulus: payload=32'h0000_0005, length=3, start pulse; rate_in toggles every 16 clocks.
  - Required: bits 1,0,1 each last 16 clocks.
  - Required: mod_out half-period is 2 clocks during bit 1 and 4 clocks during bit 0.
  - Required: done pulses once, 48 clocks after the first tick; busy falls in the same cycle.
- start while busy:
  - Stimulus: second start during a transmission with payload=32'hFFFF_FFFF.
  - Required: ignored; the original bit sequence and done timing are unchanged.
- Invalid or boundary start conditions:
  - Stimulus: length=0 with start. Required: no busy.
  - Stimulus: start coincident with a rate_in edge. Required: first bit begins at the following edge, not the coincident one.
- Reset mid-transmission:
  - Stimulus: reset asserted during bit 2 of length=8.
  - Required: mod_out and busy go 0 asynchronously; no done pulse.
  - Required: a subsequent start transmits normally from bit 0.
- Full-width transmission:
  - Stimulus: length=32, payload=32'hAAAA_AAAA.
  - Required: 32 alternating bits starting with 0.
  - Required: mod_out has no pulse shorter than 2 clocks at bit boundaries (phase continuity).
  - Required: exactly one done pulse.
